// File: rtl/dram_frame_streamer.sv
// Streams whole frames from DRAM into a show-ahead word FIFO using
// credit-limited, multi-outstanding kick/busy read bursts.
module dram_frame_streamer #(
  parameter int          BURST_WORDS     = 64,
  parameter int          FRAME_WORDS     = 1440000,
  parameter int          FIFO_DEPTH      = 4096,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] BASE_ADDR_0     = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR_1     = 32'h0100_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_continuous,
  input  logic                          i_frame_select,
  output logic                          o_kick,
  input  logic                          i_busy,
  output logic [31:0]                   o_read_num,
  output logic [31:0]                   o_read_addr,
  input  logic                          i_rd_valid,
  input  logic [31:0]                   i_rd_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [31:0]                   o_out_data,
  output logic [31:0]                   o_out_offset,
  output logic [$clog2(FIFO_DEPTH):0]   o_out_level,
  output logic                          o_active,
  output logic                          o_frame_done,
  output logic                          o_cur_buffer,
  output logic                          o_err
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = $clog2(BURST_WORDS) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] FW  = 32'(FRAME_WORDS);
  localparam logic [31:0] BWD = 32'(BURST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_clear;
  logic            w_toggle;

  logic            r_kick;
  logic            r_cur_buffer;
  logic            r_err;
  logic            r_frame_done;
  logic [31:0]     r_issue_off;
  logic [31:0]     r_out_words;
  logic [31:0]     r_wr_off;
  logic [31:0]     r_rd_off;
  logic [OW-1:0]   r_bursts;
  logic [BW-1:0]   r_q [MAX_OUTSTANDING];
  logic [QW-1:0]   r_q_head;
  logic [QW-1:0]   r_q_tail;
  logic [BW-1:0]   r_head_cnt;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [LW-1:0]   r_wp;
  logic [LW-1:0]   r_rp;
  logic [LW:0]     r_level;

  logic [31:0]     w_rem;
  logic [31:0]     w_num;
  logic [31:0]     w_base;
  logic [31:0]     w_addr;
  logic            w_full;
  logic            w_wr;
  logic            w_bad;
  logic            w_pop;
  logic            w_accept;
  logic            w_credit;
  logic            w_can_kick;
  logic            w_burst_done;
  logic            w_last;

  function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_rem    = FW - r_issue_off;
  assign w_num    = (w_rem < BWD) ? w_rem : BWD;
  assign w_base   = r_cur_buffer ? BASE_ADDR_1 : BASE_ADDR_0;
  assign w_addr   = w_base + (r_issue_off << 2);
  assign w_full   = (r_level == (LW+1)'(FIFO_DEPTH));
  assign w_wr     = i_rd_valid && (r_out_words != '0) && !w_full;
  assign w_bad    = i_rd_valid && !w_wr;
  assign w_pop    = (r_level != '0) && i_out_ready;
  assign w_accept = r_kick && i_busy;

  // Space already promised to in-flight words counts against the FIFO.
  assign w_credit = (34'(r_level) + 34'(r_out_words) + 34'(w_num))
                    <= 34'(FIFO_DEPTH);

  assign w_can_kick = (r_state == S_ISSUE) && !r_kick && !i_busy &&
                      (r_bursts < OW'(MAX_OUTSTANDING)) && w_credit;

  assign w_burst_done = w_wr && ((r_head_cnt + 1'b1) == r_q[r_q_head]);
  assign w_last       = w_wr && (r_wr_off == FW - 32'd1);

  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_toggle = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next  = S_ISSUE;
          w_clear = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_accept) w_next = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (!i_busy) w_next = (r_issue_off < FW) ? S_ISSUE : S_DRAIN;
      end
      S_DRAIN: begin
        if (r_wr_off == FW) w_next = S_DONE;
      end
      S_DONE: begin
        if (i_continuous) begin
          w_next   = S_ISSUE;
          w_clear  = 1'b1;
          w_toggle = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_kick       <= 1'b0;
      r_cur_buffer <= 1'b0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      r_issue_off  <= '0;
      r_out_words  <= '0;
      r_wr_off     <= '0;
      r_bursts     <= '0;
      r_q_head     <= '0;
      r_q_tail     <= '0;
      r_head_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_last;
      if (w_bad) r_err <= 1'b1;
      if (w_clear) r_cur_buffer <= w_toggle ? ~r_cur_buffer : i_frame_select;
      if (w_can_kick) r_kick <= 1'b1;
      else if (w_accept) r_kick <= 1'b0;
      if (w_clear) begin
        r_issue_off <= '0;
        r_out_words <= '0;
        r_wr_off    <= '0;
        r_bursts    <= '0;
        r_q_head    <= '0;
        r_q_tail    <= '0;
        r_head_cnt  <= '0;
      end else begin
        if (w_accept) r_issue_off <= r_issue_off + w_num;
        r_out_words <= r_out_words + (w_accept ? w_num : 32'd0)
                       - {31'd0, w_wr};
        if (w_wr) r_wr_off <= r_wr_off + 32'd1;
        r_bursts <= r_bursts + OW'(w_accept) - OW'(w_burst_done);
        if (w_accept) r_q_tail <= nxt(r_q_tail);
        if (w_burst_done) begin
          r_q_head   <= nxt(r_q_head);
          r_head_cnt <= '0;
        end else if (w_wr) begin
          r_head_cnt <= r_head_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_q[r_q_tail] <= BW'(w_num);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_level  <= '0;
      r_rd_off <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp     <= r_rp + 1'b1;
        r_rd_off <= (r_rd_off == FW - 32'd1) ? 32'd0 : r_rd_off + 32'd1;
      end
      r_level <= r_level + (LW+1)'(w_wr) - (LW+1)'(w_pop);
    end
  end

  assign o_kick       = r_kick;
  assign o_read_num   = r_kick ? w_num : 32'd0;
  assign o_read_addr  = r_kick ? w_addr : 32'd0;
  assign o_out_valid  = (r_level != '0);
  assign o_out_data   = o_out_valid ? r_mem[r_rp] : 32'd0;
  assign o_out_offset = r_rd_off;
  assign o_out_level  = r_level;
  assign o_active     = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_cur_buffer = r_cur_buffer;
  assign o_err        = r_err;

endmodule

// File: tb/tb_dram_frame_streamer.sv
// Bench for dram_frame_streamer: randomized DRAM/consumer agent checked
// against a frame-level model of expected commands and output words.
module tb_dram_frame_streamer;

  localparam int          BW = 32;
  localparam int          FW = 200;
  localparam int          FD = 128;
  localparam int          MO = 2;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        frame_select = 1'b0;
  logic        busy = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        kick;
  logic [31:0] read_num;
  logic [31:0] read_addr;
  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] out_offset;
  logic [7:0]  out_level;
  logic        active;
  logic        frame_done;
  logic        cur_buffer;
  logic        err;

  dram_frame_streamer #(
    .BURST_WORDS(BW), .FRAME_WORDS(FW), .FIFO_DEPTH(FD),
    .MAX_OUTSTANDING(MO), .BASE_ADDR_0(B0), .BASE_ADDR_1(B1)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_continuous(continuous),
    .i_frame_select(frame_select), .o_kick(kick), .i_busy(busy),
    .o_read_num(read_num), .o_read_addr(read_addr),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_offset(out_offset),
    .o_out_level(out_level), .o_active(active),
    .o_frame_done(frame_done), .o_cur_buffer(cur_buffer), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          num;
    int          ready;
  } burst_t;

  burst_t rq[$];
  int     hidx = 0;

  int   vectors = 0;
  int   miscompares = 0;
  bit   agent_en = 1'b1;
  bit   spur_req = 1'b0;
  int   ret_lat = 2;
  bit   ret_gap = 1'b0;
  int   rdy_mode = 1;
  int   hold = 0;
  logic m_buf = 1'b0;
  int   m_iss = 0;
  logic e_buf = 1'b0;
  int   e_off = 0;
  int   pops = 0;
  int   rw_frame = 0;
  int   fd_cnt = 0;
  logic fd_bufs[$];
  int   tb_out = 0;
  int   tb_peak = 0;
  int   cmds = 0;

  function automatic logic [31:0] base(input logic b);
    return b ? B1 : B0;
  endfunction

  function automatic logic [31:0] dw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // DRAM controller, return path and consumer, all driven on negedge.
  initial begin
    logic [31:0] ea;
    int          en;
    forever begin
      @(negedge clk);
      if (!agent_en) begin
        busy = 1'b0;
        rd_valid = 1'b0;
        out_ready = 1'b0;
        rq.delete();
        hidx = 0;
        hold = 0;
        tb_out = 0;
        rw_frame = 0;
        if (spur_req) begin
          rd_valid = 1'b1;
          rd_data = 32'hDEAD_BEEF;
          spur_req = 1'b0;
        end
      end else begin
        if (frame_done) begin
          fd_cnt++;
          fd_bufs.push_back(cur_buffer);
          vectors++;
          if (rw_frame !== FW) begin
            miscompares++;
            $display("FAIL frame_done_pos: words returned %0d, required %0d",
                     rw_frame, FW);
          end
          rw_frame = 0;
        end
        case (rdy_mode)
          0: out_ready = 1'b0;
          1: out_ready = 1'b1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid && out_ready) begin
          ea = dw(base(e_buf) + 32'(e_off) * 32'd4);
          vectors++;
          if (out_data !== ea || out_offset !== 32'(e_off)) begin
            miscompares++;
            $display("FAIL out_word: data %h off %0d, required %h off %0d",
                     out_data, out_offset, ea, e_off);
          end
          e_off++;
          pops++;
          if (e_off == FW) begin
            e_off = 0;
            e_buf = ~e_buf;
          end
        end
        rd_valid = 1'b0;
        if (rq.size() > 0 && cyc >= rq[0].ready &&
            (!ret_gap || $urandom_range(0, 2) != 0)) begin
          rd_valid = 1'b1;
          rd_data = dw(rq[0].addr + 32'(hidx) * 32'd4);
          hidx++;
          rw_frame++;
          if (hidx >= rq[0].num) begin
            void'(rq.pop_front());
            hidx = 0;
            tb_out--;
          end
        end
        if (busy) begin
          if (hold > 0) hold--;
          if (hold == 0) busy = 1'b0;
        end else if (kick && $urandom_range(0, 1) == 1) begin
          busy = 1'b1;
          hold = $urandom_range(1, 3);
          en = (FW - m_iss < BW) ? FW - m_iss : BW;
          ea = base(m_buf) + 32'(m_iss) * 32'd4;
          vectors++;
          if (read_addr !== ea || read_num !== 32'(en)) begin
            miscompares++;
            $display("FAIL cmd: addr %h num %0d, required addr %h num %0d",
                     read_addr, read_num, ea, en);
          end
          m_iss += en;
          if (m_iss >= FW) begin
            m_iss = 0;
            m_buf = ~m_buf;
          end
          rq.push_back('{addr: read_addr, num: int'(read_num),
                         ready: cyc + ret_lat});
          cmds++;
          tb_out++;
          if (tb_out > tb_peak) tb_peak = tb_out;
          vectors++;
          if (tb_out > MO) begin
            miscompares++;
            $display("FAIL outstanding: %0d bursts in flight, limit %0d",
                     tb_out, MO);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic do_start(input logic sel, input logic cont);
    @(negedge clk);
    frame_select = sel;
    continuous = cont;
    m_buf = sel;
    m_iss = 0;
    e_buf = sel;
    e_off = 0;
    pops = 0;
    rw_frame = 0;
    fd_cnt = 0;
    fd_bufs.delete();
    tb_peak = 0;
    cmds = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int nf, input int budget, input string nm);
    int n = 0;
    while ((fd_cnt < nf || active || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d frames after %0d cycles, required %0d",
               nm, fd_cnt, n, nf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++;
    if ({kick, out_valid, active, frame_done, cur_buffer, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 000000",
               {kick, out_valid, active, frame_done, cur_buffer, err});
    end
    vectors++;
    if (read_num !== 32'd0 || read_addr !== 32'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cmd: num %0d addr %h data %h, required zeros",
               read_num, read_addr, out_data);
    end
    chk("reset_level", int'(out_level), 0);
    chk("reset_offset", int'(out_offset), 0);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    ret_lat = 2;
    ret_gap = 1'b0;
    rdy_mode = 1;
    do_start(1'b0, 1'b0);
    wait_done(1, 3000, "single");
    chk("single_fd", fd_cnt, 1);
    chk("single_pops", pops, FW);
    chk("single_cmds", cmds, 7);
    if (fd_bufs.size() > 0) chk("single_buf", int'(fd_bufs[0]), 0);
    chk("single_active", int'(active), 0);
    chk("single_err", int'(err), 0);
  endtask

  task automatic test_short_burst();
    ret_lat = $urandom_range(1, 8);
    ret_gap = 1'b1;
    rdy_mode = 2;
    do_start(1'b1, 1'b0);
    wait_done(1, 4000, "short");
    chk("short_fd", fd_cnt, 1);
    chk("short_pops", pops, FW);
    chk("short_cmds", cmds, 7);
    if (fd_bufs.size() > 0) chk("short_buf", int'(fd_bufs[0]), 1);
    chk("short_err", int'(err), 0);
  endtask

  task automatic test_stall();
    ret_lat = 0;
    ret_gap = 1'b0;
    rdy_mode = 0;
    do_start(1'b0, 1'b0);
    tick(300);
    chk("stall_level", int'(out_level), FD);
    chk("stall_kick", int'(kick), 0);
    chk("stall_cmds", cmds, 4);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_pops", pops, 0);
    rdy_mode = 1;
    wait_done(1, 3000, "stall");
    chk("stall_total", pops, FW);
    chk("stall_fd", fd_cnt, 1);
    chk("stall_err", int'(err), 0);
  endtask

  task automatic test_delayed();
    ret_lat = 100;
    ret_gap = 1'b0;
    rdy_mode = 1;
    do_start(1'b0, 1'b0);
    wait_done(1, 6000, "delayed");
    chk("delayed_peak", tb_peak, MO);
    chk("delayed_pops", pops, FW);
    chk("delayed_err", int'(err), 0);
  endtask

  task automatic test_continuous();
    int n = 0;
    ret_lat = 3;
    ret_gap = 1'b1;
    rdy_mode = 2;
    do_start(1'b0, 1'b1);
    while (fd_cnt < 2 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    tick(20);
    continuous = 1'b0;
    wait_done(3, 6000, "cont");
    chk("cont_fd", fd_cnt, 3);
    chk("cont_pops", pops, 3 * FW);
    for (int i = 0; i < 3; i++) begin
      if (fd_bufs.size() > i) chk("cont_buf", int'(fd_bufs[i]), i % 2);
    end
    chk("cont_active", int'(active), 0);
    chk("cont_err", int'(err), 0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ret_lat = 10;
    ret_gap = 1'b0;
    rdy_mode = 1;
    do_start(1'b0, 1'b0);
    while (rw_frame < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", int'(rw_frame >= 40), 1);
    agent_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mid_kick", int'(kick), 0);
    chk("mid_active", int'(active), 0);
    chk("mid_level", int'(out_level), 0);
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_err_clr", int'(err), 0);
    spur_req = 1'b1;
    tick(3);
    chk("mid_err_set", int'(err), 1);
    chk("mid_level2", int'(out_level), 0);
    agent_en = 1'b1;
    do_start(1'b1, 1'b0);
    wait_done(1, 4000, "mid");
    chk("mid_pops", pops, FW);
    chk("mid_fd", fd_cnt, 1);
    chk("mid_err_sticky", int'(err), 1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_short_burst();
    test_stall();
    test_delayed();
    test_continuous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_frame_streamer.md
Name: dram_frame_streamer

Overview:
Parametrised successor of the single-burst DRAM-to-RGB reader. It streams one frame, or back-to-back frames, from DRAM into an internal word FIFO using the kick/busy read-command handshake. Up to MAX_OUTSTANDING bursts may be in flight, admitted by credit against FIFO space, and a short final burst is issued when the frame is not a multiple of the burst length. It sits between the DRAM read controller and the pixel/HDMI pipeline, and tags every output word with its frame offset.

Parameters:
BURST_WORDS, 64, words per read command (power of 2, ≥2)
FRAME_WORDS, 1440000, words per frame (1600x900)
FIFO_DEPTH, 4096, internal data FIFO depth in words (power of 2, ≥2*BURST_WORDS)
MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts (1..15)
BASE_ADDR_0, 32'h0000_0000, byte base address for frame_select=0
BASE_ADDR_1, 32'h0100_0000, byte base address for frame_select=1

Ports:
clk  in  1  clock; all logic in this domain
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a frame when idle
continuous  in  1  level; at end of frame, auto-restart on the other buffer
frame_select  in  1  buffer select, sampled on accepted start
kick  out  1  read command request
busy  in  1  controller busy; command accepted on first cycle with kick=1 and busy=1
read_num  out  32  words in the current command
read_addr  out  32  byte address = base + (word_offset<<2)
rd_valid  in  1  one returned data word per cycle
rd_data  in  32  returned data
out_valid  out  1  output word available
out_ready  in  1  consumer pop
out_data  out  32  output word
out_offset  out  32  frame word offset of out_data
out_level  out  log2(FIFO_DEPTH)+1  words held in FIFO
active  out  1  frame in progress
frame_done  out  1  1-cycle pulse when last word of frame is written
cur_buffer  out  1  frame_select currently being read
err  out  1  sticky: unexpected rd_valid or overflow; cleared only by rst

Behaviour:
- Reset: all outputs 0; FIFO flushed; offsets 0; state IDLE. Reset mid-frame abandons the frame. Words returning after reset for pre-reset commands set err.
- States: IDLE, ISSUE, ACK_WAIT, DRAIN, DONE.
- IDLE: start=1 latches frame_select into cur_buffer, clears issue_off, outstanding_words and wr_off, then moves to ISSUE. active=1 in every state except IDLE. start is ignored outside IDLE.
- ISSUE: kick=1 only when all three hold: busy=0, bursts_out < MAX_OUTSTANDING, and out_level + outstanding_words + read_num ≤ FIFO_DEPTH. kick is held until busy=1. On the accept cycle: issue_off += read_num, outstanding_words += read_num, bursts_out += 1, and the state moves to ACK_WAIT.
- ACK_WAIT: wait for busy=0. Then go to ISSUE if issue_off < FRAME_WORDS, else DRAIN.
- read_num = min(BURST_WORDS, FRAME_WORDS − issue_off). Both read_num and read_addr are stable while kick=1.
- Returned words: each rd_valid writes rd_data to the FIFO, increments wr_off, and decrements outstanding_words. bursts_out decrements when a burst's word count completes. Word counting uses a per-burst length queue of depth MAX_OUTSTANDING.
- rd_valid with outstanding_words=0, or with the FIFO full: word dropped, err=1.
- Simultaneous accept and return in one cycle: net update is outstanding_words + read_num − 1.
- DRAIN: when wr_off reaches FRAME_WORDS, pulse frame_done on that write cycle, then go to DONE.
- DONE, one cycle: if continuous=1, toggle cur_buffer, reset the offsets, and go to ISSUE. Otherwise go to IDLE with active=0.
- Output FIFO: show-ahead. A word written at cycle t produces out_valid no later than t+2. Pop occurs on out_valid & out_ready.
- out_offset: counts from 0 per frame, wraps to 0 after FRAME_WORDS−1, and follows the word order.
- out_level: updates the cycle after a write or pop. A simultaneous push and pop leaves it unchanged.
- Consumer stall: the FIFO never overflows because credit blocks kick. Draining resumes issue with no lost or duplicated words.
- Width: offsets are 32-bit and never exceed FRAME_WORDS. read_addr wraps modulo 2^32.

Test Plan:
- Single frame, FRAME_WORDS=256, BURST_WORDS=64, buffer 0, out_ready=1: 4 commands at addr 0x0,0x100,0x200,0x300 with read_num=64; 256 words in order; out_offset 0..255; one frame_done; active drops after it.
- FRAME_WORDS=200, BURST_WORDS=64, frame_select=1: commands of 64,64,64,8 at 0x0100_0000+{0,0x100,0x200,0x300}; frame_done after word 199.
- out_ready=0, FIFO_DEPTH=256, returns immediate: kick stops after 4 bursts (out_level=256). Raising out_ready resumes issue; no loss or duplication; err=0.
- Delayed returns (100 cycles), MAX_OUTSTANDING=2: never more than 2 accepted commands without completion; accept and return on the same cycle gives correct outstanding count.
- continuous=1, 3 frames: cur_buffer alternates 0,1,0; base addresses alternate; 3 frame_done pulses; out_offset restarts at 0 each frame.
- rst asserted mid-burst, then a spurious rd_valid: outputs zero, FIFO empty, err=1. A new start then completes normally.
